// File: rtl/unary_pkg.sv
// Shared constants, FSM encoding and operand-group type for the unary dot-product scheduler.
package unary_pkg;

  localparam int LANES = 16;
  localparam int OP_W  = 4;
  localparam int ACC_W = 8;
  localparam int GRP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESULT
  } sched_state_t;

  typedef logic [LANES-1:0][OP_W-1:0] op_grp_t;

  // A lane is only worth issuing when both operands are non-zero; product blocks mis-count on w=0.
  function automatic logic [LANES-1:0] lane_active(input op_grp_t w, input op_grp_t x);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (w[i] != '0) && (x[i] != '0);
    end
    return m;
  endfunction

endpackage

// File: rtl/unary_dot_scheduler_lane_done_tracker.sv
// Tracks which lanes of the in-flight group are active and which have reported done.
// Completion is combinational so the scheduler can leave WAIT in the cycle the last done arrives.
module lane_done_tracker
  import unary_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  op_grp_t          i_w,
  input  op_grp_t          i_x,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [LANES-1:0] i_done,
  output logic [LANES-1:0] o_load_active,
  output logic             o_complete
);

  logic [LANES-1:0] r_active;
  logic [LANES-1:0] r_done_seen;
  logic [LANES-1:0] w_done_now;

  assign o_load_active = lane_active(i_w, i_x);
  // Stale dones from lanes that were not issued this group are ignored through the active mask.
  assign w_done_now    = i_done & r_active;
  assign o_complete    = &(r_done_seen | w_done_now | ~r_active);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active    <= '0;
      r_done_seen <= '0;
    end else begin
      if (i_load) begin
        r_active <= o_load_active;
      end
      if (i_clear) begin
        r_done_seen <= '0;
      end else if (i_update) begin
        r_done_seen <= r_done_seen | w_done_now;
      end
    end
  end

endmodule

// File: rtl/unary_dot_scheduler.sv
// Runs one dot-product job over the 16-lane unary product array, one operand group at a time.
// Per group: 1 fetch + 1 issue + slowest lane; result is held until res_ready, job_valid ignored while busy.
module unary_dot_scheduler
  import unary_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [GRP_W-1:0] job_groups,
  input  logic             op_valid,
  output logic             op_ready,
  input  op_grp_t          op_w,
  input  op_grp_t          op_x,
  output logic [LANES-1:0] pb_in_rdy,
  output op_grp_t          pb_w,
  output op_grp_t          pb_x,
  input  logic [LANES-1:0] pb_done,
  input  logic [ACC_W-1:0] acc_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy
);

  sched_state_t     r_state;
  logic [GRP_W-1:0] r_remaining;
  logic [ACC_W-1:0] r_base;
  logic [ACC_W-1:0] r_res_data;
  logic [LANES-1:0] r_pb_in_rdy;
  op_grp_t          r_pb_w;
  op_grp_t          r_pb_x;
  logic             r_job_ready;
  logic             r_op_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_fetch_accept;
  logic [LANES-1:0] w_load_active;
  logic             w_complete;
  logic             w_last_group;

  assign w_fetch_accept = (r_state == S_FETCH) && op_valid;
  assign w_last_group   = (r_remaining == GRP_W'(1));

  lane_done_tracker u_tracker (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_load        (w_fetch_accept),
    .i_w           (op_w),
    .i_x           (op_x),
    .i_clear       (r_state == S_ISSUE),
    .i_update      (r_state == S_WAIT),
    .i_done        (pb_done),
    .o_load_active (w_load_active),
    .o_complete    (w_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_base      <= '0;
      r_res_data  <= '0;
      r_pb_in_rdy <= '0;
      r_pb_w      <= '0;
      r_pb_x      <= '0;
      r_job_ready <= 1'b1;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_pb_in_rdy <= '0;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_remaining <= job_groups;
            r_base      <= acc_value;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (job_groups == '0) begin
              r_res_data  <= '0;
              r_res_valid <= 1'b1;
              r_state     <= S_RESULT;
            end else begin
              r_op_ready <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (op_valid) begin
            r_pb_w <= op_w;
            r_pb_x <= op_x;
            // An all-zero group contributes nothing, so it retires without touching the lanes.
            if (w_load_active == '0) begin
              r_remaining <= r_remaining - GRP_W'(1);
              if (w_last_group) begin
                r_op_ready <= 1'b0;
                r_state    <= S_DRAIN;
              end
            end else begin
              r_op_ready  <= 1'b0;
              r_pb_in_rdy <= w_load_active;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_complete) begin
            r_remaining <= r_remaining - GRP_W'(1);
            if (w_last_group) begin
              r_state <= S_DRAIN;
            end else begin
              r_op_ready <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          // The accumulator cannot be cleared, so the job result is its growth since job start.
          r_res_data  <= acc_value - r_base;
          r_res_valid <= 1'b1;
          r_state     <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_job_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready = r_job_ready;
  assign op_ready  = r_op_ready;
  assign pb_in_rdy = r_pb_in_rdy;
  assign pb_w      = r_pb_w;
  assign pb_x      = r_pb_x;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_unary_dot_scheduler.sv
// Bench for unary_dot_scheduler: unary lane/accumulator environment plus a sum-of-products reference.
module tb_unary_dot_scheduler;
  import unary_pkg::*;

  localparam int LIMIT = 1200;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic             job_ready;
  logic [GRP_W-1:0] job_groups;
  logic             op_valid;
  logic             op_ready;
  op_grp_t          op_w;
  op_grp_t          op_x;
  logic [LANES-1:0] pb_in_rdy;
  op_grp_t          pb_w;
  op_grp_t          pb_x;
  logic [LANES-1:0] pb_done;
  logic [ACC_W-1:0] acc_value;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unary_dot_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_groups (job_groups),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_w       (op_w),
    .op_x       (op_x),
    .pb_in_rdy  (pb_in_rdy),
    .pb_w       (pb_w),
    .pb_x       (pb_x),
    .pb_done    (pb_done),
    .acc_value  (acc_value),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  // Environment: each strobed lane emits w*x unary pulses into a shared wrapping accumulator.
  logic             env_rst;
  int               lane_cnt [LANES];
  logic [ACC_W-1:0] acc_inc;

  always_comb begin
    acc_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!pb_in_rdy[i] && lane_cnt[i] > 0) acc_inc = acc_inc + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (env_rst) begin
      acc_value <= '0;
      pb_done   <= '0;
      for (int i = 0; i < LANES; i++) lane_cnt[i] <= 0;
    end else begin
      acc_value <= acc_value + acc_inc;
      for (int i = 0; i < LANES; i++) begin
        if (pb_in_rdy[i]) begin
          lane_cnt[i] <= int'(pb_w[i]) * int'(pb_x[i]);
          pb_done[i]  <= 1'b0;
        end else if (lane_cnt[i] > 0) begin
          lane_cnt[i] <= lane_cnt[i] - 1;
          if (lane_cnt[i] == 1) pb_done[i] <= 1'b1;
        end
      end
    end
  end

  // Monitors: every issue cycle and every op_ready cycle.
  logic [LANES-1:0] issue_q [$];
  op_grp_t          issue_w_q [$];
  op_grp_t          issue_x_q [$];
  int               op_rdy_cycles = 0;

  always @(negedge clk) begin
    if (reset_n && pb_in_rdy != '0) begin
      issue_q.push_back(pb_in_rdy);
      issue_w_q.push_back(pb_w);
      issue_x_q.push_back(pb_x);
    end
    if (op_ready) op_rdy_cycles <= op_rdy_cycles + 1;
  end

  // Reference data and model
  op_grp_t grp_w [8];
  op_grp_t grp_x [8];

  function automatic int model_sum(input int n);
    int s = 0;
    for (int g = 0; g < n; g++)
      for (int i = 0; i < LANES; i++)
        if (grp_w[g][i] != 0 && grp_x[g][i] != 0) s += int'(grp_w[g][i]) * int'(grp_x[g][i]);
    return s % 256;
  endfunction

  function automatic logic [LANES-1:0] model_mask(input int g);
    logic [LANES-1:0] m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (grp_w[g][i] != 0) && (grp_x[g][i] != 0);
    return m;
  endfunction

  task automatic fill_uniform(input int g, input int w, input int x);
    for (int i = 0; i < LANES; i++) begin
      grp_w[g][i] = OP_W'(w);
      grp_x[g][i] = OP_W'(x);
    end
  endtask

  task automatic run_job(input int n, output bit timed_out, output int res_wait);
    int guard;
    timed_out = 1'b0;
    res_wait  = 0;
    @(negedge clk);
    job_valid  = 1'b1;
    job_groups = GRP_W'(n);
    @(negedge clk);
    job_valid = 1'b0;
    for (int g = 0; g < n; g++) begin
      op_w = grp_w[g];
      op_x = grp_x[g];
      op_valid = 1'b1;
      guard = 0;
      while (!op_ready && guard < LIMIT) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= LIMIT) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= LIMIT) timed_out = 1'b1;
    res_wait = guard;
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; env_rst = 1'b1;
    job_valid = 1'b0; job_groups = '0; op_valid = 1'b0; op_w = '0; op_x = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got=%b exp=1", job_ready); end
    checks++; if (busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b op_ready=%b res_valid=%b exp=0", busy, op_ready, res_valid); end
    checks++; if (res_data !== '0 || pb_in_rdy !== '0) begin
      errors++; $display("FAIL reset_data res_data=%h pb_in_rdy=%h exp=0", res_data, pb_in_rdy); end
    checks++; if (pb_w !== '0 || pb_x !== '0) begin errors++; $display("FAIL reset_pb_ops w=%h x=%h exp=0", pb_w, pb_x); end
    env_rst = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit to; int rw;
    fill_uniform(0, 2, 3);
    run_job(1, to, rw);
    checks++; if (to || res_data !== 8'd96) begin errors++; $display("FAIL b2b_job_a got=%0d timeout=%0d exp=96", res_data, to); end
    consume();
    fill_uniform(0, 1, 1);
    run_job(1, to, rw);
    checks++; if (to || res_data !== 8'd16) begin errors++; $display("FAIL b2b_job_b got=%0d timeout=%0d exp=16", res_data, to); end
    consume();
  endtask

  task automatic test_single_hold();
    bit to; int rw; int q0;
    q0 = issue_q.size();
    fill_uniform(0, 2, 3);
    run_job(1, to, rw);
    checks++; if (to || res_data !== 8'd96) begin errors++; $display("FAIL single_result got=%0d timeout=%0d exp=96", res_data, to); end
    checks++; if (issue_q.size() - q0 != 1) begin errors++; $display("FAIL single_issue_cycles got=%0d exp=1", issue_q.size() - q0); end
    else begin
      checks++; if (issue_q[q0] !== 16'hFFFF) begin errors++; $display("FAIL single_mask got=%h exp=ffff", issue_q[q0]); end
      checks++; if (issue_w_q[q0] !== grp_w[0] || issue_x_q[q0] !== grp_x[0]) begin
        errors++; $display("FAIL single_pb_ops w=%h x=%h exp w=%h x=%h", issue_w_q[q0], issue_x_q[q0], grp_w[0], grp_x[0]); end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 8'd96) begin
        errors++; $display("FAIL single_hold cyc=%0d valid=%b data=%0d exp valid=1 data=96", c, res_valid, res_data); end
    end
    consume();
    checks++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++; $display("FAIL single_release valid=%b job_ready=%b exp 0/1", res_valid, job_ready); end
  endtask

  task automatic test_masked();
    bit to; int rw; int q0;
    q0 = issue_q.size();
    fill_uniform(0, 1, 1);
    for (int i = 0; i < 4; i++) grp_w[0][i] = '0;
    for (int i = 4; i < 8; i++) grp_x[0][i] = '0;
    run_job(1, to, rw);
    checks++; if (to || res_data !== 8'd8) begin errors++; $display("FAIL masked_result got=%0d timeout=%0d exp=8", res_data, to); end
    checks++; if (issue_q.size() - q0 != 1 || issue_q[issue_q.size()-1] !== 16'hFF00) begin
      errors++; $display("FAIL masked_mask issues=%0d last=%h exp 1 x ff00", issue_q.size() - q0,
                         (issue_q.size() > 0) ? issue_q[issue_q.size()-1] : 16'h0); end
    consume();
  endtask

  task automatic test_zero_groups();
    bit to; int rw; int q0; int r0;
    q0 = issue_q.size();
    r0 = op_rdy_cycles;
    run_job(0, to, rw);
    checks++; if (to || rw + 1 > 2) begin errors++; $display("FAIL zero_latency cycles=%0d timeout=%0d exp<=2", rw + 1, to); end
    checks++; if (res_data !== 8'd0) begin errors++; $display("FAIL zero_result got=%0d exp=0", res_data); end
    checks++; if (op_rdy_cycles != r0 || issue_q.size() != q0) begin
      errors++; $display("FAIL zero_no_traffic op_ready_cycles=%0d issues=%0d exp 0/0", op_rdy_cycles - r0, issue_q.size() - q0); end
    consume();
  endtask

  task automatic test_two_groups();
    bit to; int rw; int q0;
    q0 = issue_q.size();
    fill_uniform(0, 15, 15);
    fill_uniform(1, 15, 15);
    run_job(2, to, rw);
    checks++; if (to || res_data !== 8'd32) begin errors++; $display("FAIL two_groups_result got=%0d timeout=%0d exp=32", res_data, to); end
    checks++; if (issue_q.size() - q0 != 2) begin errors++; $display("FAIL two_groups_issues got=%0d exp=2", issue_q.size() - q0); end
    consume();
  endtask

  task automatic test_random();
    bit to; int rw; int q0; int n; int k; int r;
    logic [ACC_W-1:0] exp_res;
    logic [LANES-1:0] m;
    for (int job = 0; job < 6; job++) begin
      n = $urandom_range(1, 4);
      for (int g = 0; g < n; g++) begin
        for (int i = 0; i < LANES; i++) begin
          r = $urandom_range(0, 5);
          grp_w[g][i] = (r == 0) ? '0 : OP_W'($urandom_range(1, 15));
          grp_x[g][i] = (r == 1) ? '0 : OP_W'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 3) == 0) grp_w[g] = '0;
      end
      q0 = issue_q.size();
      run_job(n, to, rw);
      exp_res = ACC_W'(model_sum(n));
      checks++; if (to || res_data !== exp_res) begin
        errors++; $display("FAIL random_result job=%0d got=%0d timeout=%0d exp=%0d", job, res_data, to, exp_res); end
      k = q0;
      for (int g = 0; g < n; g++) begin
        m = model_mask(g);
        if (m != '0) begin
          checks++; if (k >= issue_q.size() || issue_q[k] !== m) begin
            errors++; $display("FAIL random_mask job=%0d grp=%0d got=%h exp=%h", job, g,
                               (k < issue_q.size()) ? issue_q[k] : 16'h0, m); end
          k++;
        end
      end
      checks++; if (issue_q.size() != k) begin
        errors++; $display("FAIL random_issue_count job=%0d got=%0d exp=%0d", job, issue_q.size() - q0, k - q0); end
      consume();
    end
  endtask

  task automatic test_reset_mid_job();
    bit to; int rw; int guard;
    fill_uniform(0, 15, 15);
    @(negedge clk);
    job_valid = 1'b1; job_groups = 8'd1;
    @(negedge clk);
    job_valid = 1'b0; op_w = grp_w[0]; op_x = grp_x[0]; op_valid = 1'b1;
    guard = 0;
    while (!op_ready && guard < LIMIT) begin @(negedge clk); guard++; end
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL midjob_in_wait busy=%b op_ready=%b res_valid=%b exp 1/0/0", busy, op_ready, res_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (job_ready !== 1'b1 || busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL midjob_reset_flags job_ready=%b busy=%b op_ready=%b res_valid=%b", job_ready, busy, op_ready, res_valid); end
    checks++; if (pb_w !== '0 || pb_x !== '0 || pb_in_rdy !== '0 || res_data !== '0) begin
      errors++; $display("FAIL midjob_reset_data w=%h x=%h in_rdy=%h res=%h exp 0", pb_w, pb_x, pb_in_rdy, res_data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    fill_uniform(0, 1, 1);
    run_job(1, to, rw);
    checks++; if (to || res_data !== 8'd16) begin errors++; $display("FAIL midjob_after_result got=%0d timeout=%0d exp=16", res_data, to); end
    consume();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single_hold();
    test_masked();
    test_zero_groups();
    test_two_groups();
    test_random();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unary_dot_scheduler.md
Name: unary_dot_scheduler

Overview:
Sequences one dot-product job across the 16-lane unary product array and the shared parallel accumulator. A job is a count of 16-lane operand groups. The scheduler fetches each group over a valid/ready stream, drives per-lane in_rdy/w/x, and waits for every active lane to report done. It then presents the job's result. The accumulator has no clear, so the scheduler snapshots its value at job start and returns the difference.

Parameters:
LANES, 16, number of product lanes
OP_W, 4, operand width per lane
ACC_W, 8, accumulator/result width
GRP_W, 8, width of job group count

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
job_valid  input  1  job request
job_ready  output  1  scheduler can accept a job
job_groups  input  GRP_W  number of operand groups in the job
op_valid  input  1  operand group available
op_ready  output  1  operand group accepted
op_w  input  LANES x OP_W  weights, one per lane
op_x  input  LANES x OP_W  activations, one per lane
pb_in_rdy  output  LANES  per-lane load strobe to the product blocks
pb_w  output  LANES x OP_W  registered weights to the product blocks
pb_x  output  LANES x OP_W  registered activations to the product blocks
pb_done  input  LANES  per-lane done from the product blocks
acc_value  input  ACC_W  accumulator register output
res_valid  output  1  result available
res_ready  input  1  result consumed
res_data  output  ACC_W  job result, modulo 2^ACC_W
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE; pb_in_rdy=0; pb_w=0; pb_x=0; res_valid=0; res_data=0; op_ready=0; busy=0; job_ready=1 once IDLE is active.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DRAIN, RESULT.
- IDLE:
  - job_ready=1.
  - On job_valid, latch remaining=job_groups and base=acc_value.
  - If job_groups==0: res_data=0, go to RESULT.
  - Otherwise go to FETCH.
- FETCH:
  - op_ready=1.
  - On op_valid, register op_w/op_x into pb_w/pb_x.
  - Compute active[i] = (w[i]!=0) && (x[i]!=0). Product blocks mis-count when w=0, so zero lanes are never issued.
  - If active==0: decrement remaining, then go to DRAIN if remaining hits 0, else stay in FETCH.
  - Otherwise go to ISSUE.
- ISSUE:
  - Exactly one cycle; pb_in_rdy=active. pb_w/pb_x are stable this cycle.
  - Clear the per-lane done_seen bits.
  - Go to WAIT.
- WAIT:
  - done_seen |= pb_done & active.
  - A group is complete when (done_seen | (pb_done & active) | ~active) is all ones.
  - pb_done is never high in the first cycle after a load, so the stale DONE-state done is masked by the clear in ISSUE.
  - On group complete: decrement remaining; go to DRAIN if the new value is 0, else FETCH.
- DRAIN:
  - One cycle, lets the accumulator register settle.
  - res_data = acc_value - base, modulo 2^ACC_W.
  - Go to RESULT.
- RESULT:
  - res_valid=1; res_data is held stable while res_ready is low.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
- Concurrency: at most one group is in flight. job_valid is ignored outside IDLE. op_ready is high only in FETCH.
- Latency per group: 1 (fetch) + 1 (issue) + the slowest active lane's unary run.
- Arithmetic: the accumulator and result wrap modulo 256. The scheduler does no overflow detection.
- Reset mid-job: immediate return to IDLE. The in-flight group is discarded and any partial accumulator contribution is excluded by the next job's new base.
- Inactive lanes are never strobed. Their product blocks stay in INIT/DONE with out=0, so they do not disturb the sum.

Decomposition:
- Package unary_pkg: LANES, OP_W, ACC_W constants; sched_state_t enum; operand-group typedef (logic [LANES-1:0][OP_W-1:0]).
- One sub-module, lane_done_tracker: active mask, done_seen bits, clear/update, and the all-complete flag.

Test Plan:
- 1 group, all lanes w=2, x=3 -> exactly one ISSUE cycle with pb_in_rdy=16'hFFFF; res_data=96; res_valid held until res_ready.
- 1 group with w=0 on lanes 0-3 and x=0 on lanes 4-7, others w=1, x=1 -> pb_in_rdy=16'hFF00; res_data=8.
- job_groups=0 -> no op_ready, no pb_in_rdy; RESULT with res_data=0 within 2 cycles.
- 2 groups, all lanes w=15, x=15 -> two FETCH/ISSUE/WAIT passes; res_data=7200 mod 256=32.
- Back-to-back jobs: job A (all w=2, x=3) gives 96, then job B (all w=1, x=1) -> res_data=16 while acc_value=112; base subtraction verified.
- Assert reset_n low during WAIT -> all outputs at reset values the same cycle; after release, a new job (all w=1, x=1) gives res_data=16.
